// File: rtl/rv_dmem_mmio_pkg.sv
// Shared definitions for the data-side memory subsystem: MMIO register
// offsets, STATUS bit layout and the address-decode result type.
package rv_mmio_pkg;

   // Byte offsets of the MMIO registers from the window base
   localparam logic [3:0] OFF_TXDATA = 4'h0;
   localparam logic [3:0] OFF_STATUS = 4'h4;
   localparam logic [3:0] OFF_CYCLE  = 4'h8;
   localparam logic [3:0] OFF_DROPS  = 4'hC;

   // STATUS register layout
   localparam int STAT_EMPTY_BIT = 0;
   localparam int STAT_FULL_BIT  = 1;
   localparam int STAT_COUNT_LSB = 8;
   localparam int STAT_ERR_BIT   = 16;

   // Which target the current address selects
   typedef enum logic [2:0] {
      DEC_RAM,
      DEC_TX,
      DEC_STAT,
      DEC_CYC,
      DEC_DROP,
      DEC_NONE
   } dec_e;

endpackage

// File: rtl/rv_dmem_mmio_if.sv
// Core data-port bus plus the console TX drain port.
// Handshake: a TX word transfers on a rising edge where tx_valid && tx_ready;
// tx_valid never depends on tx_ready, and tx_data is stable while tx_valid
// is high and tx_ready is low.
interface rv_dmem_mmio_if #(
   parameter int DPWIDTH = 32
) ();
   logic [DPWIDTH-1:0] dmem_addr;
   logic [DPWIDTH-1:0] dmem_dataout;
   logic               memrw;
   logic [DPWIDTH-1:0] dmem_datain;
   logic               tx_valid;
   logic [DPWIDTH-1:0] tx_data;
   logic               tx_ready;
   logic               addr_err;

   modport slave (
      input  dmem_addr, dmem_dataout, memrw, tx_ready,
      output dmem_datain, tx_valid, tx_data, addr_err
   );

   modport master (
      output dmem_addr, dmem_dataout, memrw, tx_ready,
      input  dmem_datain, tx_valid, tx_data, addr_err
   );
endinterface

// File: rtl/rv_dmem_mmio_fifo.sv
// Synchronous FIFO for the console TX path. Head word is presented from
// registered state only (no push-to-pop bypass) and reads as 0 when empty.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module rv_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         data_in,
   output logic                     full,
   input  logic                     pop,
   output logic [WIDTH-1:0]         data_out,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] store [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty    = (count == '0);
   assign full     = (count == FULL_COUNT);
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);
   assign data_out = empty ? '0 : store[rd_ptr];

   // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push) store[wr_ptr] <= data_in;
   end

endmodule

// File: rtl/rv_dmem_mmio.sv
// Data memory subsystem: decodes core accesses to a word RAM or to the MMIO
// window (console TX FIFO, STATUS, cycle counter, dropped-push counter).
// Reads are combinational so the core can latch them on the same edge.
module rv_dmem_mmio
   import rv_mmio_pkg::*;
#(
   parameter int                 DPWIDTH   = 32,
   parameter int                 RAMWORDS  = 1024,
   parameter int                 FIFODEPTH = 8,
   parameter logic [DPWIDTH-1:0] MMIO_BASE = 32'h8000_0000
) (
   input  logic             clk,
   input  logic             rst,
   rv_dmem_mmio_if.slave    bus
);
   localparam int RAW = $clog2(RAMWORDS);
   localparam int CW  = $clog2(FIFODEPTH) + 1;

   dec_e               dec;
   logic [RAW-1:0]     ram_idx;
   logic [DPWIDTH-1:0] mem [RAMWORDS];
   logic [DPWIDTH-1:0] cycle;
   logic [DPWIDTH-1:0] drops;
   logic [DPWIDTH-1:0] status;
   logic               fifo_push;
   logic               fifo_pop;
   logic               fifo_full;
   logic               fifo_empty;
   logic [CW-1:0]      fifo_count;
   logic               drop_evt;
   logic               unused_addr_bits;

   // Byte-lane bits play no part in word addressing
   assign unused_addr_bits = ^bus.dmem_addr[1:0];
   assign ram_idx          = bus.dmem_addr[RAW+1:2];

   // Address decode: low RAM, then the four-word MMIO window, else unmapped
   always_comb begin
      dec = DEC_NONE;
      if (bus.dmem_addr[DPWIDTH-1:RAW+2] == '0) begin
         dec = DEC_RAM;
      end else if (bus.dmem_addr[DPWIDTH-1:4] == MMIO_BASE[DPWIDTH-1:4]) begin
         case ({bus.dmem_addr[3:2], 2'b00})
            OFF_TXDATA: dec = DEC_TX;
            OFF_STATUS: dec = DEC_STAT;
            OFF_CYCLE:  dec = DEC_CYC;
            OFF_DROPS:  dec = DEC_DROP;
            default:    dec = DEC_NONE;
         endcase
      end
   end

   // RAM write port; a same-cycle read still sees the old word
   always_ff @(posedge clk) begin
      if (bus.memrw && dec == DEC_RAM) mem[ram_idx] <= bus.dmem_dataout;
   end

   assign fifo_push    = bus.memrw && (dec == DEC_TX);
   assign fifo_pop     = bus.tx_valid && bus.tx_ready;
   assign drop_evt     = fifo_push && fifo_full && !fifo_pop;
   assign bus.tx_valid = !fifo_empty;

   rv_fifo #(
      .WIDTH (DPWIDTH),
      .DEPTH (FIFODEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (fifo_push),
      .data_in  (bus.dmem_dataout),
      .full     (fifo_full),
      .pop      (fifo_pop),
      .data_out (bus.tx_data),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   // Free-running cycle counter; a write clears it and wins over the increment
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               cycle <= '0;
      else if (bus.memrw && dec == DEC_CYC)   cycle <= '0;
      else                                    cycle <= cycle + 1'b1;
   end

   // Saturating count of pushes rejected by a full FIFO; a write clears it
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               drops <= '0;
      else if (bus.memrw && dec == DEC_DROP)  drops <= '0;
      else if (drop_evt && drops != '1)       drops <= drops + 1'b1;
   end

   // Sticky unmapped-access flag, set by reads as well as writes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                bus.addr_err <= 1'b0;
      else if (dec == DEC_NONE) bus.addr_err <= 1'b1;
   end

   // STATUS word assembly
   always_comb begin
      status                        = '0;
      status[STAT_EMPTY_BIT]        = fifo_empty;
      status[STAT_FULL_BIT]         = fifo_full;
      status[STAT_COUNT_LSB +: CW]  = fifo_count;
      status[STAT_ERR_BIT]          = bus.addr_err;
   end

   // Combinational read mux; TXDATA and unmapped addresses read as zero
   always_comb begin
      bus.dmem_datain = '0;
      case (dec)
         DEC_RAM:  bus.dmem_datain = mem[ram_idx];
         DEC_STAT: bus.dmem_datain = status;
         DEC_CYC:  bus.dmem_datain = cycle;
         DEC_DROP: bus.dmem_datain = drops;
         default:  bus.dmem_datain = '0;
      endcase
   end

endmodule

// File: tb/tb_rv_dmem_mmio.sv
// Directed bench for rv_dmem_mmio. Drivers issue one bus access per cycle
// (inputs change 1 time unit after the rising edge); expected read data and
// expected TX words go into queues and a negedge monitor pops and compares.
module tb_rv_dmem_mmio;
   localparam int         W      = 32;
   localparam logic [W-1:0] MB     = 32'h8000_0000;
   localparam logic [W-1:0] A_TX   = MB;
   localparam logic [W-1:0] A_STAT = MB + 32'h4;
   localparam logic [W-1:0] A_CYC  = MB + 32'h8;
   localparam logic [W-1:0] A_DROP = MB + 32'hC;

   logic clk;
   logic rst;
   logic rd_chk;
   int   checks;
   int   failures;

   logic [W-1:0] exp_q[$];
   string        exp_name_q[$];
   logic [W-1:0] tx_q[$];

   rv_dmem_mmio_if #(.DPWIDTH(W)) bus ();

   rv_dmem_mmio #(
      .DPWIDTH   (W),
      .RAMWORDS  (1024),
      .FIFODEPTH (8),
      .MMIO_BASE (MB)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // ---------------- clock ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- watchdog ----------------
   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic access(input logic [W-1:0] addr, input logic [W-1:0] data, input logic we,
                         input logic chk, input logic [W-1:0] exp, input string name);
      bus.dmem_addr    = addr;
      bus.dmem_dataout = data;
      bus.memrw        = we;
      rd_chk           = chk;
      if (chk) begin
         exp_q.push_back(exp);
         exp_name_q.push_back(name);
      end
      @(posedge clk);
      #1;
      rd_chk        = 1'b0;
      bus.memrw     = 1'b0;
      bus.dmem_addr = '0;
   endtask

   task automatic rd(input logic [W-1:0] addr, input logic [W-1:0] exp, input string name);
      access(addr, '0, 1'b0, 1'b1, exp, name);
   endtask

   task automatic wr(input logic [W-1:0] addr, input logic [W-1:0] data);
      access(addr, data, 1'b1, 1'b0, '0, "");
   endtask

   task automatic push(input logic [W-1:0] data, input logic accepted);
      if (accepted) tx_q.push_back(data);
      wr(A_TX, data);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) access('0, '0, 1'b0, 1'b0, '0, "");
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      if (rd_chk) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL rd_underflow actual=%h required=none", bus.dmem_datain);
         end else begin
            check(exp_name_q.pop_front(), bus.dmem_datain, exp_q.pop_front());
         end
      end
      if (rst && bus.tx_valid && bus.tx_ready) begin
         if (tx_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL tx_unexpected actual=%h required=none", bus.tx_data);
         end else begin
            check("tx_data", bus.tx_data, tx_q.pop_front());
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      checks           = 0;
      failures         = 0;
      rst              = 1'b0;
      rd_chk           = 1'b0;
      bus.dmem_addr    = '0;
      bus.dmem_dataout = '0;
      bus.memrw        = 1'b0;
      bus.tx_ready     = 1'b0;

      #2;
      check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
      check("rst_tx_data", bus.tx_data, 32'h0);
      check("rst_addr_err", 32'(bus.addr_err), 32'h0);

      // Release between edges; the first counting edge follows, so after
      // 100 edges the read issued right after the 100th edge sees 100.
      @(negedge clk);
      #2 rst = 1'b1;
      repeat (100) @(posedge clk);
      #1;
      rd(A_CYC, 32'd100, "cycle_after_100");
      wr(A_CYC, 32'h1234_5678);
      rd(A_CYC, 32'd0, "cycle_cleared");
      rd(A_CYC, 32'd1, "cycle_next");

      // RAM
      wr(32'h0, 32'h0BAD_0000);
      wr(32'h10, 32'hDEAD_BEEF);
      rd(32'h10, 32'hDEAD_BEEF, "ram_rd");
      rd(32'h13, 32'hDEAD_BEEF, "ram_rd_lowbits");
      wr(32'hFFC, 32'h1234_5678);
      rd(32'hFFC, 32'h1234_5678, "ram_top_word");
      access(32'h10, 32'hCAFE_F00D, 1'b1, 1'b1, 32'hDEAD_BEEF, "ram_rd_during_wr");
      rd(32'h10, 32'hCAFE_F00D, "ram_new_word");

      // FIFO fill, overflow, push+pop while full, drain
      for (int i = 1; i <= 8; i++) push(32'(i), 1'b1);
      rd(A_STAT, 32'h0000_0802, "stat_full");
      push(32'd9, 1'b0);
      rd(A_DROP, 32'd1, "drops_one");
      rd(A_STAT, 32'h0000_0802, "stat_after_drop");
      bus.tx_ready = 1'b1;
      push(32'hA5, 1'b1);
      bus.tx_ready = 1'b0;
      rd(A_STAT, 32'h0000_0802, "stat_push_pop");
      rd(A_DROP, 32'd1, "drops_push_pop");
      bus.tx_ready = 1'b1;
      idle(8);
      check("drained_tx_valid", 32'(bus.tx_valid), 32'h0);
      check("drained_tx_data", bus.tx_data, 32'h0);
      rd(A_STAT, 32'h0000_0001, "stat_empty");
      push(32'h55, 1'b1);
      idle(1);
      bus.tx_ready = 1'b0;

      // Unmapped accesses
      check("addr_err_clear", 32'(bus.addr_err), 32'h0);
      rd(32'h0000_1000, 32'h0, "unmapped_ram_edge");
      check("addr_err_set", 32'(bus.addr_err), 32'h1);
      rd(32'h4000_0000, 32'h0, "unmapped_far");
      wr(32'h0000_1000, 32'h0000_0077);
      rd(32'h0, 32'h0BAD_0000, "no_alias");
      wr(A_STAT, 32'hFFFF_FFFF);
      rd(A_STAT, 32'h0001_0001, "stat_err");
      rd(A_TX, 32'h0, "txdata_reads_zero");
      idle(3);
      check("addr_err_sticky", 32'(bus.addr_err), 32'h1);

      // Asynchronous reset with three words queued (they are lost)
      push(32'h11, 1'b0);
      push(32'h22, 1'b0);
      push(32'h33, 1'b0);
      rd(A_STAT, 32'h0001_0300, "stat_three");
      check("pre_reset_valid", 32'(bus.tx_valid), 32'h1);
      #3 rst = 1'b0;
      #1;
      check("async_tx_valid", 32'(bus.tx_valid), 32'h0);
      check("async_tx_data", bus.tx_data, 32'h0);
      check("async_addr_err", 32'(bus.addr_err), 32'h0);
      bus.dmem_addr = A_CYC;
      #1 check("async_cycle", bus.dmem_datain, 32'h0);
      bus.dmem_addr = A_DROP;
      #1 check("async_drops", bus.dmem_datain, 32'h0);
      bus.dmem_addr = A_STAT;
      #1 check("async_status", bus.dmem_datain, 32'h1);
      bus.dmem_addr = '0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      rd(32'h10, 32'hCAFE_F00D, "ram_after_reset");
      rd(32'hFFC, 32'h1234_5678, "ram_top_after_reset");
      rd(A_STAT, 32'h0000_0001, "stat_after_reset");

      // DROPS clear by write
      for (int i = 1; i <= 8; i++) push(32'h100 + 32'(i), 1'b1);
      push(32'h999, 1'b0);
      rd(A_DROP, 32'd1, "drops_refill");
      wr(A_DROP, 32'hFFFF_FFFF);
      rd(A_DROP, 32'd0, "drops_cleared");
      bus.tx_ready = 1'b1;
      idle(8);
      bus.tx_ready = 1'b0;
      idle(1);

      // ---------------- final report ----------------
      check("rd_q_empty", 32'(exp_q.size()), 32'h0);
      check("tx_q_empty", 32'(tx_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
